// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
// The default widths here set the port widths of regfile_wb_arbiter and wb_kill_fifo.
package regfile_wb_pkg;

    localparam int D_WIDTH_DEF    = 32;
    localparam int A_WIDTH_DEF    = 5;
    localparam int LQ_DEPTH_DEF   = 2;
    localparam int STARVE_MAX_DEF = 4;

    // One register-file write request: destination and value.
    typedef struct packed {
        logic [A_WIDTH_DEF-1:0] rd;
        logic [D_WIDTH_DEF-1:0] data;
    } wb_req_t;

    // This enum records which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } arb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_kill_fifo.sv
// wb_kill_fifo: the buffer for load results that are waiting for the write port.
// Each entry holds {live, rd, data}. A kill request clears the live bit of every
// entry whose rd matches, including an entry written in the same cycle. The
// consumer pops dead entries without issuing a write.
// Pointers carry one extra bit, so a full FIFO and an empty FIFO can be told apart.
// Optional feature: when WB_BYPASS_EN is defined, live_mask flags every register
// that has a live entry. When WB_BYPASS_EN is undefined, live_mask is tied to zero.
module wb_kill_fifo
    import regfile_wb_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int DEPTH   = LQ_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [A_WIDTH-1:0]    push_rd,
    input  logic [D_WIDTH-1:0]    push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [A_WIDTH-1:0]    kill_rd,
    output logic                  full,
    output logic                  empty,
    output logic                  head_live,
    output logic [A_WIDTH-1:0]    head_rd,
    output logic [D_WIDTH-1:0]    head_data,
    output logic [2**A_WIDTH-1:0] live_mask
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [A_WIDTH-1:0] rd_mem_q   [DEPTH];
    logic [A_WIDTH-1:0] rd_mem_d   [DEPTH];
    logic [D_WIDTH-1:0] data_mem_q [DEPTH];
    logic [D_WIDTH-1:0] data_mem_d [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // The indices are equal when the FIFO is full or empty. The wrap bit tells the two cases apart.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    // The head is visible to the arbiter. Live bits of vacant slots are always 0.
    assign head_live = !empty && live_q[rd_idx];
    assign head_rd   = rd_mem_q[rd_idx];
    assign head_data = data_mem_q[rd_idx];

    // Next-state logic: kill, then pop the head, then push into the tail slot.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        live_d     = live_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;

        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem_q[i] == kill_rd) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            live_d[rd_idx] = 1'b0;
            rd_ptr_d       = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            // A younger ALU write to the same rd in this cycle makes the new entry dead on arrival.
            live_d[wr_idx]     = !(kill_en && (push_rd == kill_rd));
            rd_mem_d[wr_idx]   = push_rd;
            data_mem_d[wr_idx] = push_data;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
    end

    // Control state: pointers and live bits. Reset discards every buffered entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= live_d;
        end
    end

    // Payload storage for the entries.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset. Only the live bits decide whether an entry is valid.
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

`ifdef WB_BYPASS_EN
    // Hazard mask: one bit per register that has a live entry.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                live_mask[rd_mem_q[i]] = 1'b1;
            end
        end
    end
`else
    assign live_mask = '0;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: the only driver of the register-file write port (WE3/AD3/WD3).
// Single-cycle ALU results take priority over buffered load results.
// An ALU write kills every older buffered load that targets the same register (WAW ordering).
// No write to x0 ever leaves this block.
// If the load head loses STARVE_MAX times in a row, alu_stall is asserted for one
// cycle so that the head can drain.
// Optional feature: WB_BYPASS_EN drives pend_mask from the live load entries.
// When WB_BYPASS_EN is undefined, pend_mask is zero.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int D_WIDTH    = D_WIDTH_DEF,
    parameter int A_WIDTH    = A_WIDTH_DEF,
    parameter int LQ_DEPTH   = LQ_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [A_WIDTH-1:0]    alu_rd,
    input  logic [D_WIDTH-1:0]    alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [A_WIDTH-1:0]    ld_rd,
    input  logic [D_WIDTH-1:0]    ld_data,
    output logic                  alu_stall,
    output logic                  WE3,
    output logic [A_WIDTH-1:0]    AD3,
    output logic [D_WIDTH-1:0]    WD3,
    output logic [2**A_WIDTH-1:0] pend_mask
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_live;
    logic [A_WIDTH-1:0]   head_rd;
    logic [D_WIDTH-1:0]   head_data;
    logic                 ld_accept;
    logic                 ld_push;
    logic                 alu_req;
    logic                 fifo_pop;
    logic                 kill_en;
    arb_src_t             src;

    logic                 we3_q, we3_d;
    logic [A_WIDTH-1:0]   ad3_q, ad3_d;
    logic [D_WIDTH-1:0]   wd3_q, wd3_d;
    logic                 alu_stall_q, alu_stall_d;
    logic [CNT_W-1:0]     starve_q, starve_d;

    // Handshake. A full FIFO refuses loads even if the head pops in the same cycle.
    assign ld_ready  = !fifo_full && !rst;
    assign ld_accept = ld_valid && ld_ready;
    // Loads to x0 complete the handshake but are not stored.
    assign ld_push   = ld_accept && (ld_rd != '0);
    // ALU results to x0 never compete for the port.
    assign alu_req   = alu_valid && (alu_rd != '0);

    // Select the port owner for this cycle. A forced stall lets the load head win regardless of the ALU.
    always_comb begin
        src = SRC_NONE;
        if (alu_stall_q) begin
            if (head_live) begin
                src = SRC_LD;
            end
        end else if (alu_req) begin
            src = SRC_ALU;
        end else if (head_live) begin
            src = SRC_LD;
        end
    end

    // A live head pops only when it wins. A dead head pops without using the port.
    assign fifo_pop = !fifo_empty && (!head_live || (src == SRC_LD));
    assign kill_en  = (src == SRC_ALU);

    wb_kill_fifo #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (fifo_pop),
        .kill_en   (kill_en),
        .kill_rd   (alu_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .live_mask (pend_mask)
    );

    // Next write-port value. AD3/WD3 hold their previous value while WE3 is low.
    always_comb begin
        we3_d = (src != SRC_NONE);
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        unique case (src)
            SRC_ALU: begin
                ad3_d = alu_rd;
                wd3_d = alu_data;
            end
            SRC_LD: begin
                ad3_d = head_rd;
                wd3_d = head_data;
            end
            default: ;
        endcase
    end

    // Starvation relief. Count the consecutive losses of a live head to the ALU.
    // The STARVE_MAX-th loss raises alu_stall for the next cycle only.
    always_comb begin
        starve_d    = starve_q;
        alu_stall_d = 1'b0;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (head_live && (src == SRC_ALU)) begin
            if (starve_q == CNT_W'(STARVE_MAX - 1)) begin
                starve_d    = '0;
                alu_stall_d = 1'b1;
            end else begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    // Output registers and the starvation state. Reset issues no write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q       <= 1'b0;
            ad3_q       <= '0;
            wd3_q       <= '0;
            alu_stall_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            we3_q       <= we3_d;
            ad3_q       <= ad3_d;
            wd3_q       <= wd3_d;
            alu_stall_q <= alu_stall_d;
            starve_q    <= starve_d;
        end
    end

    assign WE3       = we3_q;
    assign AD3       = ad3_q;
    assign WD3       = wd3_q;
    assign alu_stall = alu_stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// A queue-based reference model predicts every registered output and ld_ready.
// Directed steps are followed by randomized traffic.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          alu_stall;
    logic          WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [31:0]   pend_mask;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alu_stall (alu_stall),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .pend_mask (pend_mask)
    );

    typedef struct {
        bit      live;
        wb_req_t req;
    } mentry_t;

    // Reference state: buffered loads in age order, plus the expected registered outputs.
    mentry_t       mq[$];
    int            m_starve = 0;
    bit            m_stall  = 1'b0;
    bit            m_we     = 1'b0;
    logic [AW-1:0] m_ad     = '0;
    logic [DW-1:0] m_wd     = '0;
    bit            outs_known = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
`ifdef WB_BYPASS_EN
        foreach (mq[i]) begin
            if (mq[i].live) m[mq[i].req.rd] = 1'b1;
        end
`endif
        return m;
    endfunction

    // Advance the model across one clock edge for the given inputs.
    task automatic model_step(input bit r, input bit av, input logic [AW-1:0] ard,
                              input logic [DW-1:0] adata, input bit lv,
                              input logic [AW-1:0] lrd, input logic [DW-1:0] ldata);
        bit      hl, alu_wins, ld_wins, accept, popped, stall_next;
        mentry_t e;
        if (r) begin
            mq.delete();
            m_starve = 0;
            m_stall  = 1'b0;
            m_we     = 1'b0;
            m_ad     = '0;
            m_wd     = '0;
            return;
        end
        hl         = (mq.size() > 0) && mq[0].live;
        alu_wins   = !m_stall && av && (ard != 0);
        ld_wins    = hl && !alu_wins;
        accept     = lv && (mq.size() < DEPTH);
        popped     = (mq.size() > 0) && (!mq[0].live || ld_wins);
        stall_next = 1'b0;

        if (alu_wins) begin
            m_we = 1'b1; m_ad = ard; m_wd = adata;
        end else if (ld_wins) begin
            m_we = 1'b1; m_ad = mq[0].req.rd; m_wd = mq[0].req.data;
        end else begin
            m_we = 1'b0;
        end

        if (mq.size() == 0 || popped) begin
            m_starve = 0;
        end else if (alu_wins && hl) begin
            m_starve++;
            if (m_starve == SMAX) begin
                stall_next = 1'b1;
                m_starve   = 0;
            end
        end
        m_stall = stall_next;

        if (popped) void'(mq.pop_front());
        if (alu_wins) begin
            foreach (mq[i]) begin
                if (mq[i].req.rd == ard) mq[i].live = 1'b0;
            end
        end
        if (accept && lrd != 0) begin
            e.live     = !(alu_wins && lrd == ard);
            e.req.rd   = lrd;
            e.req.data = ldata;
            mq.push_back(e);
        end
    endtask

    // Step one cycle: check the outputs, drive the inputs, check ld_ready, then update the model.
    task automatic step(input bit r, input bit av, input logic [AW-1:0] ard,
                        input logic [DW-1:0] adata, input bit lv,
                        input logic [AW-1:0] lrd, input logic [DW-1:0] ldata);
        @(negedge clk);
        if (outs_known) begin
            check("we3",       WE3,       m_we);
            check("ad3",       AD3,       m_ad);
            check("wd3",       WD3,       m_wd);
            check("alu_stall", alu_stall, m_stall);
            check("pend_mask", pend_mask, exp_mask());
        end
        rst = r; alu_valid = av; alu_rd = ard; alu_data = adata;
        ld_valid = lv; ld_rd = lrd; ld_data = ldata;
        #1;
        check("ld_ready", ld_ready, !r && (mq.size() < DEPTH));
        model_step(r, av, ard, adata, lv, lrd, ldata);
        if (r) outs_known = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;

        // Reset held for three cycles with a load offered.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        check("rst_ld_ready", ld_ready, 1'b0);
        post();
        check("rst_we3",   WE3,       1'b0);
        check("rst_ad3",   AD3,       5'd0);
        check("rst_wd3",   WD3,       32'd0);
        check("rst_stall", alu_stall, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        check("rel_ld_ready", ld_ready, 1'b1);

        // ALU path: the result appears one cycle later.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        post();
        check("alu_we3", WE3, 1'b1);
        check("alu_ad3", AD3, 5'd5);
        check("alu_wd3", WD3, 32'hDEADBEEF);

        // Load path: the write appears two cycles after the enqueue.
        idle(1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
        post();
        check("ld_n1_we3", WE3, 1'b0);
`ifdef WB_BYPASS_EN
        check("pend7_set", pend_mask[7], 1'b1);
`endif
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        post();
        check("ld_we3", WE3, 1'b1);
        check("ld_ad3", AD3, 5'd7);
        check("ld_wd3", WD3, 32'h11);

        // Fill the FIFO while the ALU is busy.
        step(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd9,  32'h900);
        step(1'b0, 1'b1, 5'd2, 32'h200, 1'b1, 5'd10, 32'hA00);
        step(1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd11, 32'hB00);
        check("full_ld_ready", ld_ready, 1'b0);
        idle(6);

        // WAW: the younger ALU write kills the buffered load.
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'hAA);
        step(1'b0, 1'b1, 5'd3, 32'hBB, 1'b0, '0, '0);
        post();
        check("waw_we3", WE3, 1'b1);
        check("waw_ad3", AD3, 5'd3);
        check("waw_wd3", WD3, 32'hBB);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        post();
        check("waw_silent_we3", WE3, 1'b0);
        idle(2);

        // Starvation: the head loses four times, then the stall lets it through.
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h55);
        for (int i = 0; i < SMAX; i++) step(1'b0, 1'b1, 5'd1, 32'h1000 + i, 1'b0, '0, '0);
        post();
        check("starve_stall", alu_stall, 1'b1);
        step(1'b0, 1'b1, 5'd1, 32'h2000, 1'b0, '0, '0);
        post();
        check("starve_we3",   WE3,       1'b1);
        check("starve_ad3",   AD3,       5'd4);
        check("starve_wd3",   WD3,       32'h55);
        check("starve_clear", alu_stall, 1'b0);
        idle(2);

        // x0: neither source writes register 0, but the load still handshakes.
        step(1'b0, 1'b1, 5'd0, 32'h666, 1'b1, 5'd0, 32'h77);
        check("x0_ld_ready", ld_ready, 1'b1);
        post();
        check("x0_we3_a", WE3, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        post();
        check("x0_we3_b", WE3, 1'b0);

        // Randomized traffic against the model. Registers 0..7 collide often.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) != 0,
                 AW'($urandom_range(0, 7)),
                 $urandom(),
                 $urandom_range(0, 3) != 0,
                 AW'($urandom_range(0, 7)),
                 $urandom());
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
